// File: rtl/rvc_fetch_align_pkg.sv
// Shared definitions for the compressed-instruction fetch realignment path:
// halfword buffer entry layout and the instruction-length predicate.
package rvc_fetch_align_pkg;

    // Opcode quadrant that marks a full-length (32-bit) instruction.
    localparam logic [1:0] RVC_QUADRANT_32 = 2'b11;

    // One buffered halfword plus the access-fault flag of the word it came from.
    typedef struct packed {
        logic [15:0] hw;
        logic        err;
    } hw_entry_t;

    localparam int HW_ENTRY_W = $bits(hw_entry_t);

    // True when the low two opcode bits denote a 16-bit compressed encoding.
    function automatic logic is_rvc(input logic [1:0] quadrant);
        return quadrant != RVC_QUADRANT_32;
    endfunction

endpackage

// File: rtl/rvc_fetch_align_hw_buffer.sv
// Circular halfword buffer: up to two writes and two reads per cycle,
// with read/write pointers and an occupancy count. Flush empties it
// without touching the stored data.
module rvc_hw_buffer
    import rvc_fetch_align_pkg::*;
#(
    parameter int DEPTH_HW = 4
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic                            flush,
    input  logic [1:0]                      wr_cnt,
    input  logic [HW_ENTRY_W-1:0]           wr_data0,
    input  logic [HW_ENTRY_W-1:0]           wr_data1,
    input  logic [1:0]                      rd_cnt,
    output logic [HW_ENTRY_W-1:0]           rd_data0,
    output logic [HW_ENTRY_W-1:0]           rd_data1,
    output logic [$clog2(DEPTH_HW+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = $clog2(DEPTH_HW + 1);

    hw_entry_t        mem [DEPTH_HW];
    logic [PTR_W-1:0] rdptr;
    logic [PTR_W-1:0] wrptr;
    logic [PTR_W-1:0] rdptr_p1;
    logic [PTR_W-1:0] wrptr_p1;

    assign rdptr_p1 = rdptr + PTR_W'(1);
    assign wrptr_p1 = wrptr + PTR_W'(1);

    // Head and next-to-head entries; DEPTH_HW is a power of two so the
    // pointers wrap naturally.
    assign rd_data0 = mem[rdptr];
    assign rd_data1 = mem[rdptr_p1];

    // Storage, pointers and count; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH_HW; i++) mem[i] <= '0;
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
        end else if (flush) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
        end else begin
            if (wr_cnt != 2'd0) mem[wrptr]    <= hw_entry_t'(wr_data0);
            if (wr_cnt == 2'd2) mem[wrptr_p1] <= hw_entry_t'(wr_data1);
            rdptr <= rdptr + PTR_W'(rd_cnt);
            wrptr <= wrptr + PTR_W'(wr_cnt);
            count <= count + CNT_W'(wr_cnt) - CNT_W'(rd_cnt);
        end
    end

endmodule

// File: rtl/rvc_fetch_align.sv
// Realigns word-aligned fetch data into whole 16/32-bit instructions for the
// decoder, tracking the head PC across halfword-aligned redirects and
// carrying fetch access faults through to the consumer.
module rvc_fetch_align
    import rvc_fetch_align_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_HW    = 4,
    parameter int              SUPPORT_RVC = 1,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [31:0]     fetch_data,
    input  logic            fetch_error,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_compressed,
    output logic            out_fetch_error
);

    localparam int   CNT_W  = $clog2(DEPTH_HW + 1);
    localparam logic RVC_EN = (SUPPORT_RVC != 0);

    hw_entry_t        h0;
    hw_entry_t        h1;
    hw_entry_t        wr0;
    hw_entry_t        wr1;
    logic [CNT_W-1:0] count;
    logic [1:0]       wr_cnt;
    logic [1:0]       rd_cnt;
    logic [XLEN-1:0]  head_pc;
    logic             drop_low;
    logic             is16;
    logic             take_one;
    logic             push;
    logic             pop;
    logic             redirect_hi;
    logic             unused_flush_pc0;

    // Target bit 0 never matters; instructions are at least halfword aligned.
    assign unused_flush_pc0 = flush_pc[0];
    assign redirect_hi      = flush_pc[1] & RVC_EN;

    rvc_hw_buffer #(
        .DEPTH_HW (DEPTH_HW)
    ) u_buf (
        .clk      (clk),
        .rst_b    (rst_b),
        .flush    (flush),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr0),
        .wr_data1 (wr1),
        .rd_cnt   (rd_cnt),
        .rd_data0 (h0),
        .rd_data1 (h1),
        .count    (count)
    );

    // Head length detect and output formation, from registered state only.
    always_comb begin
        is16      = RVC_EN & is_rvc(h0.hw[1:0]);
        // A faulting head leaves as a single halfword so the trap is raised
        // without waiting for a partner halfword that may never arrive.
        take_one  = is16 | h0.err;
        out_valid = is16 ? (count != '0) : (count >= CNT_W'(2));
        if (h0.err && count != '0) out_valid = 1'b1;
        out_instr       = take_one ? {16'h0, h0.hw} : {h1.hw, h0.hw};
        out_compressed  = is16 & ~h0.err;
        out_fetch_error = h0.err | (~is16 & h1.err);
        out_pc          = head_pc;
        fetch_ready     = (count <= CNT_W'(DEPTH_HW - 2));
    end

    // Push/pop handshakes; after a redirect to an odd halfword the low half
    // of the first word lies before the target and is skipped.
    always_comb begin
        push   = fetch_valid & fetch_ready & ~flush;
        pop    = out_valid & out_ready & ~flush;
        wr_cnt = 2'd0;
        rd_cnt = 2'd0;
        if (push) wr_cnt = drop_low ? 2'd1 : 2'd2;
        if (pop)  rd_cnt = take_one ? 2'd1 : 2'd2;
        wr0.hw  = drop_low ? fetch_data[31:16] : fetch_data[15:0];
        wr0.err = fetch_error;
        wr1.hw  = fetch_data[31:16];
        wr1.err = fetch_error;
    end

    // Head PC and low-half skip flag; a redirect overrides same-cycle traffic.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_pc  <= RESET_PC;
            drop_low <= 1'b0;
        end else if (flush) begin
            head_pc  <= {flush_pc[XLEN-1:2], redirect_hi, 1'b0};
            drop_low <= redirect_hi;
        end else begin
            if (pop)  head_pc  <= head_pc + (take_one ? XLEN'(2) : XLEN'(4));
            if (push) drop_low <= 1'b0;
        end
    end

endmodule
